tft_ili9341_stream: RTL
=======================

TFT_ILI9341_STREAM -- requirements
Module: tft_ili9341_stream

Interface
REQ-001 Parameter INPUT_CLK_MHZ, default 120, clk frequency in MHz used for all power-up delays.
REQ-002 Parameter WIDTH, default 240, panel columns; HEIGHT, default 320, panel rows.
REQ-003 Parameter SCK_HALF, default 1, clk cycles per tft_sck half-period (range 1..255).
REQ-004 Parameter FAST_SIM, default 0; when 1, every power-up delay is replaced by 16 clk cycles.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 tft_sdo  in  1  panel serial out; unused, no effect on behaviour.
REQ-008 tft_sck, tft_sdi, tft_dc, tft_cs, tft_reset  out  1 each  panel SPI clock, data, data/command (1 = data), chip select (active low), panel reset (active low).
REQ-009 pix_data  in  16  RGB565 pixel; pix_valid  in  1; pix_ready  out  1; pixel transfers on clk edge with pix_valid && pix_ready.
REQ-010 win_x0, win_x1  in  9; win_y0, win_y1  in  9; win_load  in  1  window request (TFT_WINDOW_EN only).
REQ-011 frame_done  out  1  one-cycle pulse after last pixel of window sent; win_err  out  1  one-cycle pulse on rejected window.

Function
REQ-012 SPI byte engine SHALL send 9-bit words {dc, byte}: mode 0, MSB first, sck idle low, sdi stable before each rising edge, dc constant for the whole byte, 16*SCK_HALF clk cycles per byte.
REQ-013 tft_cs SHALL fall one clk before first sck edge of a byte and rise only when no byte is queued at byte end; back-to-back bytes keep cs low.
REQ-014 States: RST_HOLD (tft_reset=0, 10 us) -> RST_WAIT (120 ms) -> SLEEP_OUT (send 0x11, then 5 ms) -> INIT (52-byte ILI9341 init table, 0x28 ... 0x29, 0x3A/0x55 RGB565) -> INIT_WAIT (10 ms) -> SET_WIN -> STREAM.
REQ-015 Delay counter SHALL be 28 bits, loaded with INPUT_CLK_MHZ*microseconds, and start counting only after the preceding byte has fully shifted out.
REQ-016 SET_WIN SHALL send 11 words: cmd 0x2A, x0[15:8], x0[7:0], x1[15:8], x1[7:0], cmd 0x2B, y0 hi/lo, y1 hi/lo, cmd 0x2C, using the active window zero-extended to 16 bits.
REQ-017 Active window after reset SHALL be x 0..WIDTH-1, y 0..HEIGHT-1.
REQ-018 In STREAM pix_ready SHALL be high only when the byte engine can accept the pixel high byte; it SHALL be low in all other states.
REQ-019 Each accepted pixel SHALL be sent as data bytes pix_data[15:8] then pix_data[7:0], no gap beyond byte engine framing; pix_data is captured at acceptance.
REQ-020 Pixel counter (17 bits) SHALL count to (x1-x0+1)*(y1-y0+1); after the low byte of the last pixel completes, frame_done pulses once and state returns to SET_WIN.
REQ-021 pix_valid deasserted mid-frame SHALL stall output with cs allowed to rise; counter holds.

Reset
REQ-022 During reset: tft_reset=0, tft_cs=1, tft_sck=0, tft_sdi=0, tft_dc=0, pix_ready=0, frame_done=0, win_err=0, state RST_HOLD, counters 0.
REQ-023 Reset asserted mid-byte or mid-frame SHALL abort immediately; no partial byte completes after release; sequence restarts from RST_HOLD.

Configuration
REQ-024 Macro TFT_WINDOW_EN defined: win_load captures win_* into a pending register; pending window becomes active at next SET_WIN entry (after frame_done or initial entry); latest win_load before that point wins.
REQ-025 With TFT_WINDOW_EN: request with x0>x1, y0>y1, x1>=WIDTH or y1>=HEIGHT SHALL be dropped and win_err pulse one cycle after win_load.
REQ-026 Without TFT_WINDOW_EN: win_* and win_load ignored, win_err tied 0, window fixed full-screen.

Verification
REQ-027 FAST_SIM=1, SCK_HALF=1: release reset -> tft_reset low 16 cycles, then high; first byte 0x11 dc=0; then 52 init bytes matching table in order.
REQ-028 After init, full window -> decoded words 0x2A,00,00,00,EF,0x2B,00,00,01,3F,0x2C with dc=0 only on the three commands.
REQ-029 Stream 76800 pixels of 0xF81F with pix_valid always 1 -> bytes alternate F8,1F dc=1; frame_done exactly once; 0x2A sequence follows.
REQ-030 TFT_WINDOW_EN, win_load with x 10..11, y 20..20 mid-frame -> current frame completes full-size; next SET_WIN sends 0x2A 00 0A 00 0B, 0x2B 00 14 00 14; frame_done after 2 pixels.
REQ-031 win_load with x0=5, x1=4 -> win_err pulse next cycle; window unchanged.
REQ-032 Assert reset during a pixel byte -> all outputs at reset values same cycle; restart from RST_HOLD.

Source files
------------

// File: rtl/tft_ili9341_stream.sv
// tft_ili9341_stream
//   Brings up an ILI9341 panel over a 4-wire SPI link and then streams
//   RGB565 pixels into a rectangular window, one frame after another.
//
//   Power-up sequence: hold the panel in reset, wait, send SLEEP OUT,
//   send the init table, wait, then alternate between programming the
//   window (CASET/PASET/RAMWR) and streaming one window's worth of pixels.
//
//   Optional feature macro: TFT_WINDOW_EN
//     defined   : win_load requests a new window, applied at the next
//                 window programming step; invalid requests pulse win_err.
//     undefined : window is fixed to the full panel, win_* ignored.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   tft_sdo             : panel serial out (not used)
//   tft_sck/sdi/dc/cs   : SPI clock, data, data(1)/command(0), select (low)
//   tft_reset           : panel reset, active low
//   pix_data/valid/ready: RGB565 pixel stream, accepted on valid && ready
//   win_x0/x1/y0/y1     : requested window corners (inclusive)
//   win_load            : window request strobe
//   frame_done          : one-cycle pulse after the last pixel of a window
//   win_err             : one-cycle pulse when a window request is rejected
module tft_ili9341_stream #(
  parameter int unsigned INPUT_CLK_MHZ = 120,
  parameter int unsigned WIDTH         = 240,
  parameter int unsigned HEIGHT        = 320,
  parameter int unsigned SCK_HALF      = 1,
  parameter int unsigned FAST_SIM      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tft_sdo,
  output logic        tft_sck,
  output logic        tft_sdi,
  output logic        tft_dc,
  output logic        tft_cs,
  output logic        tft_reset,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [8:0]  win_x0,
  input  logic [8:0]  win_x1,
  input  logic [8:0]  win_y0,
  input  logic [8:0]  win_y1,
  input  logic        win_load,
  output logic        frame_done,
  output logic        win_err
);

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_WAIT,
    SLEEP_OUT,
    INIT,
    INIT_WAIT,
    SET_WIN,
    STREAM
  } state_t;

  localparam logic [27:0] DLY_HOLD  = (FAST_SIM != 0) ? 28'd16 : 28'(INPUT_CLK_MHZ * 10);
  localparam logic [27:0] DLY_WAIT  = (FAST_SIM != 0) ? 28'd16 : 28'(INPUT_CLK_MHZ * 120000);
  localparam logic [27:0] DLY_SLEEP = (FAST_SIM != 0) ? 28'd16 : 28'(INPUT_CLK_MHZ * 5000);
  localparam logic [27:0] DLY_INIT  = (FAST_SIM != 0) ? 28'd16 : 28'(INPUT_CLK_MHZ * 10000);

  localparam logic [7:0] HALF_MAX    = 8'(SCK_HALF - 1);
  localparam logic [7:0] CS_LEAD_CNT = (SCK_HALF > 1) ? 8'(SCK_HALF - 2) : 8'd0;
  localparam logic [8:0] X1_FULL     = 9'(WIDTH - 1);
  localparam logic [8:0] Y1_FULL     = 9'(HEIGHT - 1);

  // Init table as {dc, byte}; dc=0 marks a command byte.
  function automatic logic [8:0] init_word(input logic [5:0] i);
    case (i)
      6'd0:    init_word = 9'h028;
      6'd1:    init_word = 9'h0CF;
      6'd2:    init_word = 9'h100;
      6'd3:    init_word = 9'h183;
      6'd4:    init_word = 9'h130;
      6'd5:    init_word = 9'h0ED;
      6'd6:    init_word = 9'h164;
      6'd7:    init_word = 9'h103;
      6'd8:    init_word = 9'h112;
      6'd9:    init_word = 9'h181;
      6'd10:   init_word = 9'h0E8;
      6'd11:   init_word = 9'h185;
      6'd12:   init_word = 9'h101;
      6'd13:   init_word = 9'h179;
      6'd14:   init_word = 9'h0CB;
      6'd15:   init_word = 9'h139;
      6'd16:   init_word = 9'h12C;
      6'd17:   init_word = 9'h100;
      6'd18:   init_word = 9'h134;
      6'd19:   init_word = 9'h102;
      6'd20:   init_word = 9'h0F7;
      6'd21:   init_word = 9'h120;
      6'd22:   init_word = 9'h0EA;
      6'd23:   init_word = 9'h100;
      6'd24:   init_word = 9'h100;
      6'd25:   init_word = 9'h0C0;
      6'd26:   init_word = 9'h126;
      6'd27:   init_word = 9'h0C1;
      6'd28:   init_word = 9'h111;
      6'd29:   init_word = 9'h0C5;
      6'd30:   init_word = 9'h135;
      6'd31:   init_word = 9'h13E;
      6'd32:   init_word = 9'h0C7;
      6'd33:   init_word = 9'h1BE;
      6'd34:   init_word = 9'h036;
      6'd35:   init_word = 9'h148;
      6'd36:   init_word = 9'h03A;
      6'd37:   init_word = 9'h155;
      6'd38:   init_word = 9'h0B1;
      6'd39:   init_word = 9'h100;
      6'd40:   init_word = 9'h11B;
      6'd41:   init_word = 9'h0F2;
      6'd42:   init_word = 9'h108;
      6'd43:   init_word = 9'h026;
      6'd44:   init_word = 9'h101;
      6'd45:   init_word = 9'h0B7;
      6'd46:   init_word = 9'h107;
      6'd47:   init_word = 9'h0B6;
      6'd48:   init_word = 9'h10A;
      6'd49:   init_word = 9'h182;
      6'd50:   init_word = 9'h127;
      default: init_word = 9'h029;
    endcase
  endfunction

  state_t      state, state_n;

  // byte engine
  logic        q_valid;
  logic [8:0]  q_word;
  logic        busy;
  logic [2:0]  bit_idx;
  logic [7:0]  hcnt;
  logic [7:0]  shreg;
  logic        sck_q, sdi_q, dc_q, cs_q;
  logic        half_end, byte_end, eng_load, eng_idle, cs_lead;

  // sequencer
  logic        push;
  logic [8:0]  push_word;
  logic [27:0] dly_cnt, dly_val;
  logic        armed, dly_run, dly_load, dly_fire;
  logic [5:0]  idx;
  logic        idx_inc;
  logic        sent, sent_set;
  logic [16:0] pix_cnt, pix_total;
  logic [7:0]  lo_byte;
  logic        lo_pend, lo_push, accept;
  logic        frame_end, frame_done_q;
  logic        win_activate;
  logic [8:0]  win_word;
  logic [9:0]  dx, dy;

  logic [8:0]  act_x0, act_x1, act_y0, act_y1;
  logic        unused_sdo;

  assign unused_sdo = tft_sdo;

  // ---------------------------------------------------------------------
  // SPI byte engine with a one-word holding register
  // ---------------------------------------------------------------------
  assign half_end = (hcnt == HALF_MAX);
  assign byte_end = busy && sck_q && half_end && (bit_idx == 3'd0);
  assign eng_load = q_valid && (!busy || byte_end);
  assign eng_idle = !busy && !q_valid;
  // cs must drop exactly one clk before the first rising sck edge
  assign cs_lead  = (SCK_HALF > 1) && !sck_q && (bit_idx == 3'd7) && (hcnt == CS_LEAD_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_word  <= '0;
      busy    <= 1'b0;
      bit_idx <= '0;
      hcnt    <= '0;
      shreg   <= '0;
      sck_q   <= 1'b0;
      sdi_q   <= 1'b0;
      dc_q    <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      if (push) begin
        q_valid <= 1'b1;
        q_word  <= push_word;
      end else if (eng_load) begin
        q_valid <= 1'b0;
      end

      if (eng_load) begin
        busy    <= 1'b1;
        shreg   <= q_word[7:0];
        sdi_q   <= q_word[7];
        dc_q    <= q_word[8];
        bit_idx <= 3'd7;
        hcnt    <= '0;
        sck_q   <= 1'b0;
        if (SCK_HALF == 1) cs_q <= 1'b0;
      end else if (busy) begin
        if (half_end) begin
          hcnt  <= '0;
          sck_q <= ~sck_q;
          if (sck_q) begin
            if (bit_idx == 3'd0) begin
              busy <= 1'b0;
              cs_q <= 1'b1;
            end else begin
              bit_idx <= bit_idx - 3'd1;
              sdi_q   <= shreg[bit_idx - 3'd1];
            end
          end
        end else begin
          hcnt <= hcnt + 8'd1;
        end
        if (cs_lead) cs_q <= 1'b0;
      end
    end
  end

  assign tft_sck   = sck_q;
  assign tft_sdi   = sdi_q;
  assign tft_dc    = dc_q;
  assign tft_cs    = cs_q;
  assign tft_reset = (state != RST_HOLD);

  // ---------------------------------------------------------------------
  // Window registers
  // ---------------------------------------------------------------------
`ifdef TFT_WINDOW_EN
  localparam logic [9:0] W10 = 10'(WIDTH);
  localparam logic [9:0] H10 = 10'(HEIGHT);

  logic [8:0] pend_x0, pend_x1, pend_y0, pend_y1;
  logic       win_bad, win_err_q;

  assign win_bad = (win_x0 > win_x1) || (win_y0 > win_y1) ||
                   ({1'b0, win_x1} >= W10) || ({1'b0, win_y1} >= H10);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_x0   <= '0;
      pend_x1   <= X1_FULL;
      pend_y0   <= '0;
      pend_y1   <= Y1_FULL;
      act_x0    <= '0;
      act_x1    <= X1_FULL;
      act_y0    <= '0;
      act_y1    <= Y1_FULL;
      win_err_q <= 1'b0;
    end else begin
      win_err_q <= win_load && win_bad;
      if (win_load && !win_bad) begin
        pend_x0 <= win_x0;
        pend_x1 <= win_x1;
        pend_y0 <= win_y0;
        pend_y1 <= win_y1;
      end
      if (win_activate) begin
        act_x0 <= pend_x0;
        act_x1 <= pend_x1;
        act_y0 <= pend_y0;
        act_y1 <= pend_y1;
      end
    end
  end

  assign win_err = win_err_q;
`else
  logic unused_win;

  assign unused_win = ^{win_x0, win_x1, win_y0, win_y1, win_load, win_activate};
  assign act_x0     = '0;
  assign act_x1     = X1_FULL;
  assign act_y0     = '0;
  assign act_y1     = Y1_FULL;
  assign win_err    = 1'b0;
`endif

  assign dx        = {1'b0, act_x1} - {1'b0, act_x0} + 10'd1;
  assign dy        = {1'b0, act_y1} - {1'b0, act_y0} + 10'd1;
  assign pix_total = {7'b0, dx} * {7'b0, dy};

  always_comb begin
    win_word = 9'h02C;
    case (idx)
      6'd0:    win_word = 9'h02A;
      6'd1:    win_word = {1'b1, 7'b0, act_x0[8]};
      6'd2:    win_word = {1'b1, act_x0[7:0]};
      6'd3:    win_word = {1'b1, 7'b0, act_x1[8]};
      6'd4:    win_word = {1'b1, act_x1[7:0]};
      6'd5:    win_word = 9'h02B;
      6'd6:    win_word = {1'b1, 7'b0, act_y0[8]};
      6'd7:    win_word = {1'b1, act_y0[7:0]};
      6'd8:    win_word = {1'b1, 7'b0, act_y1[8]};
      6'd9:    win_word = {1'b1, act_y1[7:0]};
      default: win_word = 9'h02C;
    endcase
  end

  // ---------------------------------------------------------------------
  // Delay timer: armed only once the engine has drained, so each wait
  // is measured from the end of the preceding byte.
  // ---------------------------------------------------------------------
  always_comb begin
    dly_val = '0;
    case (state)
      RST_HOLD:  dly_val = DLY_HOLD;
      RST_WAIT:  dly_val = DLY_WAIT;
      SLEEP_OUT: dly_val = DLY_SLEEP;
      INIT_WAIT: dly_val = DLY_INIT;
      default:   dly_val = '0;
    endcase
  end

  assign dly_run  = (state == RST_HOLD) || (state == RST_WAIT) ||
                    (state == INIT_WAIT) || ((state == SLEEP_OUT) && sent);
  assign dly_load = dly_run && !armed && eng_idle;
  assign dly_fire = dly_run && armed && (dly_cnt <= 28'd1);

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RST_HOLD;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    push         = 1'b0;
    push_word    = '0;
    idx_inc      = 1'b0;
    sent_set     = 1'b0;
    accept       = 1'b0;
    lo_push      = 1'b0;
    frame_end    = 1'b0;
    pix_ready    = 1'b0;
    case (state)
      RST_HOLD:  if (dly_fire) state_n = RST_WAIT;
      RST_WAIT:  if (dly_fire) state_n = SLEEP_OUT;
      SLEEP_OUT: begin
        if (!sent) begin
          if (!q_valid) begin
            push      = 1'b1;
            push_word = 9'h011;
            sent_set  = 1'b1;
          end
        end else if (dly_fire) begin
          state_n = INIT;
        end
      end
      INIT: begin
        if (!q_valid) begin
          push      = 1'b1;
          push_word = init_word(idx);
          idx_inc   = 1'b1;
          if (idx == 6'd51) state_n = INIT_WAIT;
        end
      end
      INIT_WAIT: if (dly_fire) state_n = SET_WIN;
      SET_WIN: begin
        if (!q_valid) begin
          push      = 1'b1;
          push_word = win_word;
          idx_inc   = 1'b1;
          if (idx == 6'd10) state_n = STREAM;
        end
      end
      STREAM: begin
        if (lo_pend) begin
          if (!q_valid) begin
            push      = 1'b1;
            push_word = {1'b1, lo_byte};
            lo_push   = 1'b1;
          end
        end else if (pix_cnt != pix_total) begin
          pix_ready = !q_valid;
          if (pix_valid && !q_valid) begin
            accept    = 1'b1;
            push      = 1'b1;
            push_word = {1'b1, pix_data[15:8]};
          end
        end else if (eng_idle) begin
          frame_end = 1'b1;
          state_n   = SET_WIN;
        end
      end
      default: state_n = RST_HOLD;
    endcase
  end

  assign win_activate = (state_n == SET_WIN) && (state != SET_WIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly_cnt      <= '0;
      armed        <= 1'b0;
      idx          <= '0;
      sent         <= 1'b0;
      pix_cnt      <= '0;
      lo_byte      <= '0;
      lo_pend      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (dly_load) begin
        dly_cnt <= dly_val;
        armed   <= 1'b1;
      end else if (dly_fire) begin
        dly_cnt <= '0;
        armed   <= 1'b0;
      end else if (armed) begin
        dly_cnt <= dly_cnt - 28'd1;
      end

      if (state_n != state) idx <= '0;
      else if (idx_inc)     idx <= idx + 6'd1;

      if (state_n != state) sent <= 1'b0;
      else if (sent_set)    sent <= 1'b1;

      if (state != STREAM) pix_cnt <= '0;
      else if (accept)     pix_cnt <= pix_cnt + 17'd1;

      if (accept) begin
        lo_byte <= pix_data[7:0];
        lo_pend <= 1'b1;
      end else if (lo_push || state != STREAM) begin
        lo_pend <= 1'b0;
      end

      frame_done_q <= frame_end;
    end
  end

  assign frame_done = frame_done_q;

endmodule
